// File: rtl/lfsr_range_gen.sv
// Galois LFSR random source: a free-running raw output plus a bounded
// [0, limit) request port built on rejection sampling with a forced fallback.
module lfsr_range_gen #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0]  SEED      = 16'hACE1,
    parameter int                OUT_WIDTH = 8,
    parameter int                MAX_TRIES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_in,
    input  logic                 req,
    input  logic [OUT_WIDTH-1:0] limit,
    output logic                 busy,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] out,
    output logic [OUT_WIDTH-1:0] raw
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TRY_ONE  = TW'(1);

    typedef enum logic {
        IDLE,
        SAMPLE
    } fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [WIDTH-1:0]     state_q, state_d;
    logic [OUT_WIDTH-1:0] lim_q, lim_d;
    logic [TW-1:0]        tries_q, tries_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 valid_q, valid_d;

    logic [WIDTH-1:0]     lfsr_next;
    logic [OUT_WIDTH-1:0] lim_m1;
    logic [OUT_WIDTH-1:0] mask;
    logic [OUT_WIDTH-1:0] cand;
    logic                 accept;

    assign lfsr_next = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);

    // Smear the highest set bit of (limit-1) downward; limit 0 wraps to all ones.
    always_comb begin
        lim_m1 = lim_q - OUT_WIDTH'(1);
        mask   = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            mask = mask | (lim_m1 >> i);
        end
    end

    assign cand   = state_q[OUT_WIDTH-1:0] & mask;
    assign accept = (lim_q == '0) || (cand < lim_q);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        lim_d   = lim_q;
        tries_d = tries_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (seed_load) begin
            state_d = (seed_in == '0) ? SEED : seed_in;
            fsm_d   = IDLE;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (req) begin
                        lim_d   = limit;
                        tries_d = TRY_ONE;
                        fsm_d   = SAMPLE;
                        state_d = lfsr_next;
                    end else if (en) begin
                        state_d = lfsr_next;
                    end
                end
                SAMPLE: begin
                    state_d = lfsr_next;
                    if (accept) begin
                        out_d   = cand;
                        valid_d = 1'b1;
                        fsm_d   = IDLE;
                    end else if (tries_q == TRY_LAST) begin
                        // cand < 2*limit here, so one subtraction lands in range.
                        out_d   = cand - lim_q;
                        valid_d = 1'b1;
                        fsm_d   = IDLE;
                    end else begin
                        tries_d = tries_q + TRY_ONE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= SEED;
            lim_q   <= '0;
            tries_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            lim_q   <= lim_d;
            tries_q <= tries_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = (fsm_q == SAMPLE);
    assign valid = valid_q;
    assign out   = out_q;
    assign raw   = state_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Bench for lfsr_range_gen: directed cases, then randomized traffic checked
// by a scoreboard fed from a behavioural sampling model.
`timescale 1ns/1ps
module tb_lfsr_range_gen;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          MAX_T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [7:0]  limit;
    logic        busy, valid;
    logic [7:0]  out, raw;
    logic        busy1, valid1;
    logic [7:0]  out1, raw1;

    lfsr_range_gen #(.MAX_TRIES(MAX_T)) u_dut (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .limit(limit), .busy(busy),
        .valid(valid), .out(out), .raw(raw)
    );

    lfsr_range_gen #(.MAX_TRIES(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .limit(limit), .busy(busy1),
        .valid(valid1), .out(out1), .raw(raw1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        int         e;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] mdl_state;
    logic [7:0]  last1_out;
    int          last1_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                      name, act, act, exp, exp, cyc);
    endfunction

    function automatic logic [15:0] lstep(logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
    endfunction

    // Mask = (smallest power of two >= limit) - 1; limit 0 means full range.
    function automatic int mask_of(int l);
        int p = 1;
        if (l == 0) return 255;
        while (p < l) p = p * 2;
        return p - 1;
    endfunction

    task automatic model_req(input int l, output int o, output int att);
        int          m;
        int          c;
        logic [15:0] s;
        m   = mask_of(l);
        s   = lstep(mdl_state);
        att = 0;
        o   = 0;
        for (int t = 1; t <= MAX_T; t++) begin
            c   = int'(s[7:0]) & m;
            s   = lstep(s);
            att = t;
            if (l == 0 || c < l) begin
                o = c;
                break;
            end
            if (t == MAX_T) o = c - l;
        end
        mdl_state = s;
    endtask

    always @(negedge clk) begin
        if (valid1) begin
            last1_out = out1;
            last1_cyc = cyc;
        end
        if (valid) begin
            if (sb.size() == 0) begin
                check("valid_without_req", int'(valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_out", int'(out), int'(e.o));
                check("sb_valid_edge", cyc, e.e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        mdl_state = SEED;
    endtask

    task automatic do_req(input int l, output int att);
        int   o;
        exp_t e;
        req       = 1'b1;
        limit     = l[7:0];
        seed_load = 1'b0;
        en        = 1'($urandom % 2);
        model_req(l, o, att);
        e.o = o[7:0];
        e.e = cyc + 1 + att;
        sb.push_back(e);
        tick();
        for (int k = 0; k < att; k++) begin
            check("busy_sample", int'(busy), 1);
            req   = 1'($urandom % 2);
            limit = 8'($urandom);
            en    = 1'($urandom % 2);
            tick();
        end
        req = 1'b0;
        check("busy_done", int'(busy), 0);
        check("raw_after_req", int'(raw), int'(mdl_state[7:0]));
    endtask

    task automatic idle_cycle();
        en        = 1'($urandom % 2);
        req       = 1'b0;
        seed_load = ($urandom % 8 == 0);
        seed_in   = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
        if (seed_load) begin
            req   = 1'($urandom % 2);
            limit = 8'($urandom);
            mdl_state = (seed_in == 16'h0) ? SEED : seed_in;
        end else if (en) begin
            mdl_state = lstep(mdl_state);
        end
        tick();
        check("raw_idle", int'(raw), int'(mdl_state[7:0]));
        seed_load = 1'b0;
        req       = 1'b0;
    endtask

    initial begin
        logic [7:0] walk [3];
        int         att;
        int         e0;
        walk = '{8'h70, 8'h38, 8'h9C};
        reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
        req = 1'b0; limit = 8'h0;
        mdl_state = SEED;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_raw", int'(raw), 'hE1);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_raw_dut1", int'(raw1), 'hE1);

        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mdl_state = lstep(mdl_state);
            check("en_walk", int'(raw), int'(walk[i]));
        end
        en = 1'b0;

        do_reset();
        do_req(0, att);
        check("lim0_out", int'(out), 'h70);
        check("lim0_attempts", att, 1);

        do_reset();
        e0 = cyc + 1;
        do_req(100, att);
        check("lim100_out", int'(out), 56);
        check("lim100_attempts", att, 2);
        check("fallback_out", int'(last1_out), 12);
        check("fallback_edge", last1_cyc, e0 + 1);

        do_reset();
        do_req(1, att);
        check("lim1_out", int'(out), 0);
        check("lim1_attempts", att, 1);

        en = 1'b1; seed_load = 1'b1; seed_in = 16'h0;
        tick();
        seed_load = 1'b0; en = 1'b0;
        mdl_state = SEED;
        check("seed_zero_raw", int'(raw), 'hE1);

        do_req(0, att);
        check("pre_abort_out", int'(out), 'h70);
        req = 1'b1; limit = 8'd5;
        tick();
        check("abort_busy_before", int'(busy), 1);
        req = 1'b0; seed_load = 1'b1; seed_in = 16'h1234;
        tick();
        seed_load = 1'b0;
        mdl_state = 16'h1234;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_out", int'(out), 'h70);
        check("abort_raw", int'(raw), 'h34);
        tick();
        tick();
        check("abort_quiet", int'(valid), 0);

        req = 1'b1; limit = 8'd100;
        tick();
        req = 1'b0;
        check("arst_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_raw", int'(raw), 'hE1);
        check("arst_busy", int'(busy), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_out", int'(out), 0);
        @(negedge clk);
        reset     = 1'b0;
        mdl_state = SEED;

        repeat (250) begin
            if ($urandom % 3 == 0) do_req(int'($urandom_range(0, 255)), att);
            else idle_cycle();
        end

        req = 1'b0; seed_load = 1'b0; en = 1'b0;
        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
